// File: rtl/core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | core_pkg                                                                   |
// | Shared widths, fetch entry type and PC helpers for the core front end.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package core_pkg;

    localparam int XLEN    = 32;
    localparam int ILEN    = 32;
    localparam int PC_STEP = 4;

    localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~XLEN'(PC_STEP - 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instruction;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_fifo                                                                 |
// | Synchronous FIFO of fetch entries with synchronous flush; head is zero     |
// | whenever the FIFO is empty.                                                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_W'(DEPTH));
    assign count  = count_q;
    assign do_pop = pop & ~empty;
    assign head   = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instruction_fetch                                                          |
// | PC sequencing, 1-cycle imem request/response tracking, redirect flush and  |
// | buffered valid/ready delivery of {pc, instruction} to the decoder.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module instruction_fetch
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] instruction,
    output logic [XLEN-1:0] inst_pc
);

    localparam int              CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0]  DEPTH_W = (CNT_W + 1)'(FIFO_DEPTH);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic             inflight_q, inflight_d;
    logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;

    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    fetch_entry_t     fifo_head;
    fetch_entry_t     push_entry;
    logic             push;
    logic             pop;
    logic             issue;
    logic [CNT_W:0]   outstanding;

    // Buffered plus in-flight words bound the issue so the FIFO cannot overflow.
    assign outstanding = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign issue       = rst_n & ~redirect_valid & (outstanding < DEPTH_W);

    assign imem_req    = issue;
    assign imem_addr   = pc_q;

    assign push        = inflight_q & ~redirect_valid;
    assign push_entry  = '{pc: inflight_pc_q, instruction: imem_rdata};
    assign pop         = inst_valid & inst_ready;

    assign inst_valid  = ~fifo_empty;
    assign instruction = fifo_head.instruction;
    assign inst_pc     = fifo_head.pc;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
        end else if (issue) begin
            pc_d          = pc_q + XLEN'(PC_STEP);
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && fifo_full));
        end
    end

endmodule

`default_nettype wire
